// File: rtl/imm_field_extract.sv
// Decode-front immediate slicer: packs the scattered immediate of an RV64 instruction
// into a 20-bit field, tags its extension class, and buffers it in a 2-entry skid FIFO.
// Optional per-entry encoding-illegal flag enabled by defining IMM_FIELD_ILLEGAL_CHECK_EN.

package pipes;
   typedef enum logic [2:0] {
      EXT_NULL = 3'd0,
      EXT_ADDI = 3'd1,
      EXT_LUI  = 3'd2,
      EXT_SD   = 3'd3,
      EXT_JAL  = 3'd4,
      EXT_BEQ  = 3'd5
   } im_ext_t;
endpackage

module imm_field_extract #(
   parameter int PC_W = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [PC_W-1:0]     in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [19:0]         out_imm,
   output pipes::im_ext_t      out_im_ext,
   output logic [31:0]         out_instr,
   output logic [PC_W-1:0]     out_pc,
   output logic                out_illegal
);

   typedef struct packed {
      logic [19:0]        imm;
      pipes::im_ext_t     ext;
      logic [31:0]        instr;
      logic [PC_W-1:0]    pc;
`ifdef IMM_FIELD_ILLEGAL_CHECK_EN
      logic               illegal;
`endif
   } entry_t;

   // Slot 0 is always the head; slot 1 only holds data while count_q == 2.
   entry_t     slot_q [2];
   entry_t     slot_d [2];
   logic [1:0] count_q;
   logic [1:0] count_d;

   entry_t     new_entry;
   logic       push;
   logic       pop;

   always_comb begin
      new_entry       = '0;
      new_entry.instr = in_instr;
      new_entry.pc    = in_pc;
      new_entry.ext   = pipes::EXT_NULL;
      new_entry.imm   = 20'd0;
      case (in_instr[6:0])
         7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
            new_entry.ext = pipes::EXT_ADDI;
            new_entry.imm = {8'b0, in_instr[31:20]};
         end
         7'b0110111, 7'b0010111: begin
            new_entry.ext = pipes::EXT_LUI;
            new_entry.imm = in_instr[31:12];
         end
         7'b0100011: begin
            new_entry.ext = pipes::EXT_SD;
            new_entry.imm = {8'b0, in_instr[31:25], in_instr[11:7]};
         end
         7'b1101111: begin
            new_entry.ext = pipes::EXT_JAL;
            new_entry.imm = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
         end
         7'b1100011: begin
            new_entry.ext = pipes::EXT_BEQ;
            new_entry.imm = {8'b0, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
         end
         default: begin
            new_entry.ext = pipes::EXT_NULL;
            new_entry.imm = 20'd0;
         end
      endcase
`ifdef IMM_FIELD_ILLEGAL_CHECK_EN
      // Immediate-free opcodes that are still legal: OP, OP-32, SYSTEM, MISC-MEM.
      if (in_instr[1:0] != 2'b11) begin
         new_entry.illegal = 1'b1;
      end else if (new_entry.ext == pipes::EXT_NULL) begin
         case (in_instr[6:0])
            7'b0110011, 7'b0111011, 7'b1110011, 7'b0001111: new_entry.illegal = 1'b0;
            default:                                        new_entry.illegal = 1'b1;
         endcase
      end else begin
         new_entry.illegal = 1'b0;
      end
`endif
   end

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      slot_d[0] = slot_q[0];
      slot_d[1] = slot_q[1];
      count_d   = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               slot_d[count_q[0]] = new_entry;
               count_d            = count_q + 2'd1;
            end
            2'b01: begin
               slot_d[0] = slot_q[1];
               count_d   = count_q - 2'd1;
            end
            // Both only happen at count 1, so the newcomer replaces the head.
            2'b11: begin
               slot_d[0] = new_entry;
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q   <= 2'd0;
         slot_q[0] <= '0;
         slot_q[1] <= '0;
      end else begin
         count_q   <= count_d;
         slot_q[0] <= slot_d[0];
         slot_q[1] <= slot_d[1];
      end
   end

   assign out_imm    = slot_q[0].imm;
   assign out_im_ext = slot_q[0].ext;
   assign out_instr  = slot_q[0].instr;
   assign out_pc     = slot_q[0].pc;
`ifdef IMM_FIELD_ILLEGAL_CHECK_EN
   assign out_illegal = slot_q[0].illegal;
`else
   assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_field_extract.sv
// Self-checking bench for imm_field_extract: directed vector table, hand-written
// backpressure/flush/reset sequences, and a randomized run against a queue model.
module tb_imm_field_extract;
   import pipes::*;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_imm;
   im_ext_t     out_im_ext;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   imm_field_extract #(.PC_W(64)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_im_ext(out_im_ext), .out_instr(out_instr), .out_pc(out_pc),
      .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } item_t;
   item_t mq[$];

`ifdef IMM_FIELD_ILLEGAL_CHECK_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   // Reference: immediate bits expressed as branch/jump/store offsets from the ISA encoding.
   function automatic void ref_decode(input logic [31:0] ins, output logic [19:0] imm,
                                      output im_ext_t ext, output logic ill);
      logic [20:0] off;
      logic [6:0]  opc;
      opc = ins[6:0];
      imm = 20'd0;
      ext = EXT_NULL;
      off = '0;
      if (opc == 7'h13 || opc == 7'h1B || opc == 7'h03 || opc == 7'h67) begin
         ext = EXT_ADDI;
         imm = 20'(ins[31:20]);
      end else if (opc == 7'h37 || opc == 7'h17) begin
         ext = EXT_LUI;
         imm = ins[31:12];
      end else if (opc == 7'h23) begin
         ext = EXT_SD;
         off[11:5] = ins[31:25];
         off[4:0]  = ins[11:7];
         imm = 20'(off[11:0]);
      end else if (opc == 7'h6F) begin
         ext = EXT_JAL;
         off[20]    = ins[31];
         off[10:1]  = ins[30:21];
         off[11]    = ins[20];
         off[19:12] = ins[19:12];
         imm = off[20:1];
      end else if (opc == 7'h63) begin
         ext = EXT_BEQ;
         off[12]   = ins[31];
         off[10:5] = ins[30:25];
         off[4:1]  = ins[11:8];
         off[11]   = ins[7];
         imm = 20'(off[12:1]);
      end
      ill = 1'b0;
      if (ILL_EN) begin
         if (ins[1:0] != 2'b11) ill = 1'b1;
         else if (ext == EXT_NULL && !(opc == 7'h33 || opc == 7'h3B || opc == 7'h73 || opc == 7'h0F))
            ill = 1'b1;
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [19:0] imm;
      im_ext_t     ext;
      logic        ill;
      chk("in_ready", 64'(in_ready), 64'(mq.size() != 2));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         ref_decode(mq[0].instr, imm, ext, ill);
         chk("out_imm", 64'(out_imm), 64'(imm));
         chk("out_im_ext", 64'(out_im_ext), 64'(ext));
         chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
         chk("out_pc", out_pc, mq[0].pc);
         chk("out_illegal", 64'(out_illegal), 64'(ill));
      end
   endtask

   // One clock: predict handshakes from pre-edge state, advance model, check after edge.
   task automatic step();
      bit    push;
      bit    pop;
      item_t it;
      push = in_valid && (mq.size() != 2);
      pop  = out_ready && (mq.size() != 0);
      it.instr = in_instr;
      it.pc    = in_pc;
      @(posedge clk);
      if (flush) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(it);
      end
      #1;
      compare_all();
      $display("cyc t=%0t push=%0d pop=%0d flush=%0d depth=%0d head=%08h", $time, push, pop,
               flush, mq.size(), out_instr);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = {$urandom(), $urandom()};
      out_ready = rdy;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [19:0] imm;
      im_ext_t     ext;
   } vec_t;
   vec_t vecs[8];

   function automatic logic [31:0] rand_instr();
      logic [6:0] opcs[16];
      logic [31:0] r;
      opcs = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h37, 7'h17, 7'h23, 7'h6F,
               7'h63, 7'h33, 7'h3B, 7'h73, 7'h0F, 7'h7F, 7'h00, 7'h2B};
      r = $urandom();
      if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 15)];
      return r;
   endfunction

   initial begin
      vecs[0] = '{32'hFFF00093, 20'h00FFF, EXT_ADDI};
      vecs[1] = '{32'h123452B7, 20'h12345, EXT_LUI};
      vecs[2] = '{32'h0020B423, 20'h00008, EXT_SD};
      vecs[3] = '{32'hFFDFF06F, 20'hFFFFE, EXT_JAL};
      vecs[4] = '{32'hFE000CE3, 20'h00FFC, EXT_BEQ};
      vecs[5] = '{32'h00208033, 20'h00000, EXT_NULL};
      vecs[6] = '{32'h00813083, 20'h00008, EXT_ADDI};
      vecs[7] = '{32'h00001517, 20'h00001, EXT_LUI};

      reset = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      chk("rst_out_ext", 64'(out_im_ext), 64'(EXT_NULL));
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_out_illegal", 64'(out_illegal), 64'd0);
      reset = 1'b1;

      // Single push into an empty FIFO, one-cycle latency, then drains.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vecs[i].instr, 1'b1);
         step();
         chk("vec_valid", 64'(out_valid), 64'd1);
         chk("vec_imm", 64'(out_imm), 64'(vecs[i].imm));
         chk("vec_ext", 64'(out_im_ext), 64'(vecs[i].ext));
         drive(1'b0, 32'h0, 1'b1);
         step();
         chk("vec_drained", 64'(out_valid), 64'd0);
      end

      // Back-to-back LUI then SD.
      drive(1'b1, 32'h123452B7, 1'b1);
      step();
      chk("b2b_head0", 64'(out_imm), 64'h12345);
      drive(1'b1, 32'h0020B423, 1'b1);
      step();
      chk("b2b_head1", 64'(out_imm), 64'h00008);
      chk("b2b_ext1", 64'(out_im_ext), 64'(EXT_SD));
      drive(1'b0, 32'h0, 1'b1);
      step();

      // Backpressure: A, B accepted, C waits; then drain in order.
      drive(1'b1, 32'hFFF00093, 1'b0);
      step();
      drive(1'b1, 32'h123452B7, 1'b0);
      step();
      drive(1'b1, 32'h0020B423, 1'b0);
      step();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_A", 64'(out_instr), 64'hFFF00093);
      step();
      chk("bp_still_A", 64'(out_instr), 64'hFFF00093);
      out_ready = 1'b1;
      step();
      chk("bp_head_B", 64'(out_instr), 64'h123452B7);
      step();
      chk("bp_head_C", 64'(out_instr), 64'h0020B423);
      chk("bp_count1", 64'(in_ready), 64'd1);
      drive(1'b0, 32'h0, 1'b1);
      step();
      chk("bp_empty", 64'(out_valid), 64'd0);

      // Flush with FIFO full and a pending offer.
      drive(1'b1, 32'hFFDFF06F, 1'b0);
      step();
      drive(1'b1, 32'hFE000CE3, 1'b0);
      step();
      drive(1'b1, 32'h00813083, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);
      drive(1'b0, 32'h0, 1'b1);
      step();
      chk("flush_dropped", 64'(out_valid), 64'd0);

      // Asynchronous reset with the FIFO full.
      drive(1'b1, 32'hFFF00093, 1'b0);
      step();
      step();
      chk("prerst_full", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      mq.delete();
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_imm", 64'(out_imm), 64'd0);
      chk("arst_ext", 64'(out_im_ext), 64'(EXT_NULL));
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_rel_ready", 64'(in_ready), 64'd1);
      chk("arst_rel_valid", 64'(out_valid), 64'd0);

      // All-zero word: EXT_NULL, illegal only when the check is built in.
      drive(1'b1, 32'h00000000, 1'b1);
      step();
      chk("zero_ext", 64'(out_im_ext), 64'(EXT_NULL));
      chk("zero_illegal", 64'(out_illegal), 64'(ILL_EN));
      drive(1'b0, 32'h0, 1'b1);
      step();

      // Randomized traffic against the queue model.
      for (int i = 0; i < 500; i++) begin
         drive(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0));
         flush = ($urandom_range(0, 24) == 0);
         step();
      end
      flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_field_extract.md
Name: imm_field_extract

Overview:
- Decode-front stage that produces the raw immediate and its extension type for the immediate sign-extender.
- Takes a fetched 32-bit RV64 instruction plus PC and slices the scattered immediate bits into a packed 20-bit field.
- Classifies the field as an im_ext_t (pipes package) and holds the result in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Sits between the fetch/decode pipeline register and the decode-stage immediate sign-extender.

Parameters:
- PC_W, 64, width of the PC carried alongside each entry.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- out_imm  out  20  packed raw immediate (u20)
- out_im_ext  out  im_ext_t  extension type
- out_instr  out  32  instruction passed through
- out_pc  out  PC_W  PC passed through
- out_illegal  out  1  encoding-illegal flag (see Optional Feature)

Behaviour:
- Classification by opcode in_instr[6:0], computed combinationally at push time and stored with the entry:
  - 0010011, 0011011, 0000011, 1100111 -> EXT_ADDI; imm = {8'b0, instr[31:20]}
  - 0110111, 0010111 -> EXT_LUI; imm = instr[31:12]
  - 0100011 -> EXT_SD; imm = {8'b0, instr[31:25], instr[11:7]}
  - 1101111 -> EXT_JAL; imm = {instr[31], instr[19:12], instr[20], instr[30:21]}
  - 1100011 -> EXT_BEQ; imm = {8'b0, instr[31], instr[7], instr[30:25], instr[11:8]}
  - all other opcodes -> EXT_NULL; imm = 0
- Storage: 2 entries, FIFO order, plus a 2-bit count.
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
- in_ready = (count != 2), driven from registered state only; no combinational path from out_ready.
- out_valid = (count != 0); out_* always reflect the head entry.
- Latency: a push at edge N is visible on out_* after edge N (one cycle), when the FIFO was empty.
- Simultaneous events:
  - count 1, push and pop in the same cycle: count stays 1 and the new entry becomes head.
  - count 2: no push is possible; a pop drops count to 1.
  - count 0: a pop cannot occur.
- Flush has priority over everything. At the next edge count = 0, a same-cycle push is dropped, and a same-cycle pop is irrelevant.
- Reset (asserted asynchronously, any time, including mid-transfer): count = 0, out_valid = 0, in_ready = 1 after deassertion. Entry storage, and therefore out_imm, out_instr, out_pc and out_illegal, clears to 0; out_im_ext clears to EXT_NULL.
- Stability: out_* hold stable while out_valid = 1 and out_ready = 0.

Optional Feature:
- Macro: IMM_FIELD_ILLEGAL_CHECK_EN.
- Defined: out_illegal is stored per entry and is 1 when either:
  - instr[1:0] != 2'b11, or
  - the opcode falls in the EXT_NULL class and is not one of 0110011, 0111011, 1110011, 0001111.
  - Entries flagged illegal still carry EXT_NULL and imm 0.
- Not defined: out_illegal is tied to 0 and no extra storage bit exists.

Test Plan:
- Empty FIFO, out_ready = 1, push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid = 1, out_imm = 0x00FFF, out_im_ext = EXT_ADDI; the following cycle out_valid = 0.
- Push 0x123452B7 (lui x5,0x12345) then 0x0020B423 (sd x2,8(x1)) back-to-back -> heads in order are 0x12345/EXT_LUI, then 0x00008/EXT_SD.
- Push 0xFFDFF06F (jal x0,-4) -> out_imm = 0xFFFFE, EXT_JAL. Push 0xFE000CE3 (beq x0,x0,-8) -> out_imm = 0x00FFC, EXT_BEQ. Push 0x00208033 (add) -> out_imm = 0, EXT_NULL.
- Backpressure: out_ready = 0, offer A, B, C each cycle -> A and B accepted, in_ready = 0 while C waits, out_* stable on A. Raise out_ready -> A, B, C delivered in order, with count 1 steady during simultaneous push/pop.
- Flush: count = 2 with in_valid = 1 and flush = 1 -> next cycle out_valid = 0, in_ready = 1, and the offered instruction is not delivered.
- Assert reset with count = 2 -> out_valid = 0 immediately (asynchronous); after release in_ready = 1. With IMM_FIELD_ILLEGAL_CHECK_EN defined, pushing 0x00000000 -> out_illegal = 1, EXT_NULL.
